// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared types, constants and helpers for the whack-a-mole round controller.
//   state_t      : round FSM states (IDLE, PLAY, DONE)
//   bcd2_t       : two-digit BCD value {tens, ones}
//   BCD_W        : width of one BCD digit
//   MAX_MOLES    : largest supported mole count
//   LFSR_TAPS    : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   bcd_inc_sat  : two-digit BCD increment saturating at 99
//   bcd_gt       : two-digit BCD greater-than (tens first, then ones)
// -----------------------------------------------------------------------------
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_W     = 4;
  localparam int MAX_MOLES = 4;

  // Bit n-1 set for each tap n of the polynomial x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  function automatic bcd2_t bcd_inc_sat(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.tens == 4'd9 && v.ones == 4'd9) begin
      r = v;
    end else if (v.ones == 4'd9) begin
      r.ones = '0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic logic bcd_gt(input bcd2_t a, input bcd2_t b);
    return (a.tens > b.tens) || ((a.tens == b.tens) && (a.ones > b.ones));
  endfunction

endpackage

// File: rtl/whack_lfsr8.sv
// -----------------------------------------------------------------------------
// whack_lfsr8
// Free-running 8-bit Fibonacci LFSR used to pick the next mole.
//   ClockIn : system clock
//   Reset   : synchronous, active-high; loads SEED (must be nonzero)
//   lfsr_o  : current LFSR state
// -----------------------------------------------------------------------------
module whack_lfsr8
  import whack_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       ClockIn,
  input  logic       Reset,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/whack_round_ctrl.sv
// -----------------------------------------------------------------------------
// whack_round_ctrl
// Round controller and score keeper for the whack-a-mole game. Starts and ends
// rounds against the game timer, lights one mole at a time, detects hits on
// the key inputs and keeps a saturating two-digit BCD score.
//
// Ports
//   ClockIn     : system clock (50 MHz)
//   Reset       : synchronous, active-high
//   start_key   : start button level (synchronised)
//   keys        : whack button levels, one per mole (synchronised)
//   tick        : one-cycle 1 Hz enable from the rate divider
//   time_up     : round-expired flag from the game timer
//   game_start  : high while a round is in play
//   game_done   : high after a round has ended
//   mole        : one-hot lit mole, zero when none is lit
//   score_ones  : BCD units of current score
//   score_tens  : BCD tens of current score
//   high_ones   : BCD units of best score
//   high_tens   : BCD tens of best score
//
// Build option
//   WHACK_HIGH_SCORE_EN : when defined, keeps a best-score register updated at
//                         the end of every round; otherwise high_* read zero.
// -----------------------------------------------------------------------------
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int         NUM_MOLES  = 4,
  parameter int         MOLE_TICKS = 2,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                 ClockIn,
  input  logic                 Reset,
  input  logic                 start_key,
  input  logic [NUM_MOLES-1:0] keys,
  input  logic                 tick,
  input  logic                 time_up,
  output logic                 game_start,
  output logic                 game_done,
  output logic [NUM_MOLES-1:0] mole,
  output logic [BCD_W-1:0]     score_ones,
  output logic [BCD_W-1:0]     score_tens,
  output logic [BCD_W-1:0]     high_ones,
  output logic [BCD_W-1:0]     high_tens
);

  localparam int         IDX_W       = (NUM_MOLES == 4) ? 2 : 1;
  localparam logic [3:0] MOLE_RELOAD = 4'(MOLE_TICKS - 1);

  state_t                 state_q;
  logic                   game_start_q;
  logic                   game_done_q;
  logic [NUM_MOLES-1:0]   mole_q;
  bcd2_t                  score_q;
  bcd2_t                  score_d;
  logic [3:0]             spawn_cnt_q;
  logic                   start_q;
  logic                   start_prev_q;
  logic [NUM_MOLES-1:0]   keys_q;
  logic [NUM_MOLES-1:0]   keys_prev_q;

  logic [7:0]             lfsr_w;
  logic                   lfsr_unused;
  logic                   start_press;
  logic [NUM_MOLES-1:0]   key_press;
  logic                   hit;
  logic [NUM_MOLES-1:0]   spawn_mole;

  whack_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .lfsr_o  (lfsr_w)
  );

  // Only the low index bits choose the mole; the rest just keep the sequence long.
  assign lfsr_unused = ^lfsr_w;

  assign start_press = start_q & ~start_prev_q;
  assign key_press   = keys_q & ~keys_prev_q;
  // mole_q is one-hot, so any number of simultaneous presses yields one hit at most.
  assign hit         = |(key_press & mole_q);
  assign spawn_mole  = NUM_MOLES'(1) << lfsr_w[IDX_W-1:0];

  always_comb begin
    score_d = score_q;
    if (state_q == PLAY && hit) begin
      score_d = bcd_inc_sat(score_q);
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q      <= IDLE;
      game_start_q <= 1'b0;
      game_done_q  <= 1'b0;
      mole_q       <= '0;
      score_q      <= '0;
      spawn_cnt_q  <= '0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      keys_q       <= '0;
      keys_prev_q  <= '0;
    end else begin
      start_q      <= start_key;
      start_prev_q <= start_q;
      keys_q       <= keys;
      keys_prev_q  <= keys_q;

      case (state_q)
        IDLE, DONE: begin
          if (start_press) begin
            state_q      <= PLAY;
            game_start_q <= 1'b1;
            game_done_q  <= 1'b0;
            score_q      <= '0;
            mole_q       <= spawn_mole;
            spawn_cnt_q  <= MOLE_RELOAD;
          end
        end
        PLAY: begin
          score_q <= score_d;
          if (time_up) begin
            // Expiry wins over any tick in the same cycle: no spawn.
            state_q      <= DONE;
            game_start_q <= 1'b0;
            game_done_q  <= 1'b1;
            mole_q       <= '0;
          end else if (tick && spawn_cnt_q == '0) begin
            // A spawn overrides the clear-on-hit; the hit was already scored.
            mole_q      <= spawn_mole;
            spawn_cnt_q <= MOLE_RELOAD;
          end else begin
            if (tick) begin
              spawn_cnt_q <= spawn_cnt_q - 4'd1;
            end
            if (hit) begin
              mole_q <= '0;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          game_start_q <= 1'b0;
          game_done_q  <= 1'b0;
          mole_q       <= '0;
        end
      endcase
    end
  end

`ifdef WHACK_HIGH_SCORE_EN
  bcd2_t high_q;

  // Compare against score_d so a hit landing with time_up is included.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      high_q <= '0;
    end else if (state_q == PLAY && time_up && bcd_gt(score_d, high_q)) begin
      high_q <= score_d;
    end
  end

  assign high_ones = high_q.ones;
  assign high_tens = high_q.tens;
`else
  assign high_ones = '0;
  assign high_tens = '0;
`endif

  assign game_start = game_start_q;
  assign game_done  = game_done_q;
  assign mole       = mole_q;
  assign score_ones = score_q.ones;
  assign score_tens = score_q.tens;

endmodule

// File: doc/whack_round_ctrl.md
Name: whack_round_ctrl

Overview:
- Round controller and score keeper for the whack-a-mole game.
- Sits directly upstream and downstream of the game timer:
  - drives the timer's start level (game_start) and done/clear level (game_done);
  - consumes the timer's expiry flag (time_up) and the 1 Hz rate-divider pulse (tick).
- Chooses which mole is lit, detects player hits on the key inputs, and keeps a 2-digit BCD score for the hex decoders.

Parameters:
- NUM_MOLES, 4, number of moles/keys; legal values are 2 or 4 only.
- MOLE_TICKS, 2, number of tick pulses each mole stays up before a new mole spawns; range 1..15.
- LFSR_SEED, 8'hA5, reset value of the 8-bit mole LFSR; must be nonzero.

Ports:
- ClockIn  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-high
- start_key  in  1  start button level, active-high, already synchronised
- keys  in  NUM_MOLES  whack buttons, level, active-high, already synchronised
- tick  in  1  one-cycle enable pulse at 1 Hz from the rate divider
- time_up  in  1  round-expired flag from the game timer
- game_start  out  1  high while in PLAY
- game_done  out  1  high while in DONE
- mole  out  NUM_MOLES  one-hot active mole; all-zero means no mole
- score_ones  out  4  BCD units digit of the score
- score_tens  out  4  BCD tens digit of the score
- high_ones  out  4  BCD units digit of the best score
- high_tens  out  4  BCD tens digit of the best score

Behaviour:
- Reset (synchronous, active-high, sampled on rising edge of ClockIn):
  - state=IDLE; mole=0; score=00; high=00; edge-detect registers=0; lfsr=LFSR_SEED.
  - Reset during PLAY abandons the round immediately; high score is also cleared.
- Edge detection:
  - start_key and keys are registered each cycle.
  - A press is current & ~previous, i.e. it is seen one cycle after the input rises.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Free-runs every cycle in every state, so mole order depends on player timing.
  - Mole index = lfsr[log2(NUM_MOLES)-1:0].
- FSM states: IDLE, PLAY, DONE. All outputs are registered.
  - IDLE:
    - On a start press: go to PLAY, score<=00, mole<=onehot(index), spawn_cnt<=MOLE_TICKS-1.
  - PLAY:
    - game_start=1.
    - On a tick: if spawn_cnt==0, mole<=onehot(index) and spawn_cnt<=MOLE_TICKS-1; otherwise spawn_cnt decrements.
    - Hit condition: some pressed key index matches the lit mole bit. On a hit: score +1 (BCD), mole<=0 until the next spawn.
    - Presses on unlit keys are ignored, with no penalty.
    - Several keys pressed in the same cycle: at most one hit is counted.
    - Start presses are ignored.
    - On time_up=1: go to DONE, mole<=0.
  - DONE:
    - game_done=1; score is held.
    - On a start press: go directly to PLAY with the same actions as IDLE→PLAY.
- Simultaneous events in PLAY:
  - hit with a spawning tick: the hit is scored against the old mole, and the new mole loads (spawn wins the mole register).
  - hit with time_up: the hit counts, then the state goes to DONE.
  - tick with time_up: no spawn.
- BCD arithmetic:
  - ones wraps 9→0 with a carry into tens.
  - The score saturates at 99; further hits do not change it.

Optional Feature:
- Macro: WHACK_HIGH_SCORE_EN.
- Defined:
  - On entry to DONE, if the final score > high (BCD compare, tens then ones), high<=score.
  - high is cleared only by Reset.
- Undefined: high_ones and high_tens are tied to 0 and no register is built.

Decomposition:
- Shared package whack_pkg holds:
  - the state enum {IDLE, PLAY, DONE};
  - BCD_W=4;
  - MAX_MOLES=4;
  - the LFSR tap constant.
- Sub-module whack_lfsr8 (seed parameter, free-running, 8-bit output) is instantiated once.
- The BCD incrementer is a function in whack_pkg.

Test Plan:
- Reset mid-PLAY with score=07: assert Reset for 1 cycle → next cycle state=IDLE, mole=0, score=00, game_start=0.
- Start press from IDLE → two cycles later game_start=1 and mole has exactly one bit set. Press the matching key → score=01 and mole=0.
- MOLE_TICKS=2 in PLAY: apply 2 tick pulses → a new one-hot mole appears on the 2nd tick. Press an unlit key → score unchanged.
- Score at 09, hit → score_tens=1 and score_ones=0. Score at 99, hit → score stays 99.
- Hit and time_up in the same cycle with score=04 → score=05, game_done=1, mole=0. A later start press → game_start=1 and score=00.
- With WHACK_HIGH_SCORE_EN: round 1 ends at 12, round 2 ends at 08 → high=12 after both rounds. Without the macro → high=00 throughout.
